// File: rtl/ps2_mouse_device.sv
// Device-side PS/2 mouse: generates the PS/2 clock, answers host commands, sends 3-byte packets.
// Latency: an accepted packet starts on the line once the filtered clock is high (HALF_PERIOD per phase).
// Backpressure: PKT_READY only while streaming, idle and with an empty queue; nothing is buffered beyond the queue.
//
// Ports: CLK/RESET (async active-low); CLK_MOUSE/DATA_MOUSE open-drain PS/2 lines (0 or z);
//        PKT_* packet offer (valid/ready); STREAM_EN, CMD_BYTE, CMD_VALID/CMD_ERROR pulses, BUSY status.
module ps2_mouse_device #(
  parameter int HALF_PERIOD = 3500,
  parameter int RTS_SETTLE  = 1000,
  parameter int FILTER_LEN  = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire        CLK_MOUSE,
  inout  wire        DATA_MOUSE,
  input  logic [7:0] PKT_STATUS,
  input  logic [7:0] PKT_DX,
  input  logic [7:0] PKT_DY,
  input  logic       PKT_VALID,
  output logic       PKT_READY,
  output logic       STREAM_EN,
  output logic [7:0] CMD_BYTE,
  output logic       CMD_VALID,
  output logic       CMD_ERROR,
  output logic       BUSY
);

  localparam int CNT_MAX = (2 * HALF_PERIOD > RTS_SETTLE) ? 2 * HALF_PERIOD : RTS_SETTLE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, TX_HI, TX_LO, TX_GAP, RX_WAIT, RX_LO, RX_HI, RX_ACK_LO, RX_ACK_HI
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [9:0]      rx_q, rx_d;
  logic [7:0]      q0_q, q1_q, q2_q, q0_d, q1_d, q2_d;
  logic [1:0]      qcnt_q, qcnt_d;
  logic            stream_q, stream_d;
  logic [7:0]      cmd_byte_q, cmd_byte_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            cmd_error_q, cmd_error_d;

  logic [FILTER_LEN-1:0] clk_sh_q, dat_sh_q;
  logic                  clk_f_q, dat_f_q;

  logic        clk_low, dat_low;
  logic        hp_done;
  logic [15:0] tx_frame;
  logic        frame_ok;

  // Open-drain drivers: only ever pull low or release.
  assign CLK_MOUSE  = clk_low ? 1'b0 : 1'bz;
  assign DATA_MOUSE = dat_low ? 1'b0 : 1'bz;

  assign PKT_READY = stream_q && (qcnt_q == 2'd0) && (state_q == IDLE);
  assign STREAM_EN = stream_q;
  assign CMD_BYTE  = cmd_byte_q;
  assign CMD_VALID = cmd_valid_q;
  assign CMD_ERROR = cmd_error_q;
  assign BUSY      = (state_q != IDLE);

  assign hp_done  = (cnt_q == CW'(HALF_PERIOD - 1));
  // Bits 0..10 are start, data LSB first, odd parity, stop; upper padding keeps any 4-bit index in range.
  assign tx_frame = {5'b11111, 1'b1, ~^q0_q, q0_q, 1'b0};
  assign frame_ok = (rx_q[8] == ~^rx_q[7:0]) && rx_q[9];

  // Glitch filters: a level is accepted only after FILTER_LEN equal samples.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clk_sh_q <= '1;
      dat_sh_q <= '1;
      clk_f_q  <= 1'b1;
      dat_f_q  <= 1'b1;
    end else begin
      clk_sh_q <= {clk_sh_q[FILTER_LEN-2:0], CLK_MOUSE};
      dat_sh_q <= {dat_sh_q[FILTER_LEN-2:0], DATA_MOUSE};
      if (&clk_sh_q)       clk_f_q <= 1'b1;
      else if (~|clk_sh_q) clk_f_q <= 1'b0;
      if (&dat_sh_q)       dat_f_q <= 1'b1;
      else if (~|dat_sh_q) dat_f_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      rx_q        <= '0;
      q0_q        <= '0;
      q1_q        <= '0;
      q2_q        <= '0;
      qcnt_q      <= '0;
      stream_q    <= 1'b0;
      cmd_byte_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      rx_q        <= rx_d;
      q0_q        <= q0_d;
      q1_q        <= q1_d;
      q2_q        <= q2_d;
      qcnt_q      <= qcnt_d;
      stream_q    <= stream_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_d       = bit_q;
    rx_d        = rx_q;
    q0_d        = q0_q;
    q1_d        = q1_q;
    q2_d        = q2_q;
    qcnt_d      = qcnt_q;
    stream_d    = stream_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    cmd_error_d = 1'b0;
    clk_low     = 1'b0;
    dat_low     = 1'b0;

    if (PKT_READY && PKT_VALID) begin
      q0_d   = PKT_STATUS;
      q1_d   = PKT_DX;
      q2_d   = PKT_DY;
      qcnt_d = 2'd3;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (clk_f_q && !dat_f_q) begin
          state_d = RX_WAIT;
        end else if (qcnt_q != 2'd0 && clk_f_q) begin
          state_d = TX_HI;
          bit_d   = '0;
        end
      end
      TX_HI: begin
        dat_low = ~tx_frame[bit_q];
        // The filtered clock still shows our own low phase for FILTER_LEN+1 cycles,
        // so host inhibit is only trusted after that.
        if (bit_q <= 4'd9 && cnt_q > CW'(FILTER_LEN + 1) && !clk_f_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (hp_done) begin
          state_d = TX_LO;
          cnt_d   = '0;
        end
      end
      TX_LO: begin
        clk_low = 1'b1;
        dat_low = ~tx_frame[bit_q];
        if (hp_done) begin
          cnt_d = '0;
          if (bit_q == 4'd10) begin
            q0_d    = q1_q;
            q1_d    = q2_q;
            q2_d    = 8'h00;
            qcnt_d  = qcnt_q - 2'd1;
            state_d = TX_GAP;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = TX_HI;
          end
        end
      end
      TX_GAP: begin
        if (cnt_q == CW'(2 * HALF_PERIOD - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      RX_WAIT: begin
        if (dat_f_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!clk_f_q) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(RTS_SETTLE - 1)) begin
          state_d = RX_LO;
          bit_d   = '0;
          cnt_d   = '0;
        end
      end
      RX_LO: begin
        clk_low = 1'b1;
        if (hp_done) begin
          state_d = RX_HI;
          cnt_d   = '0;
        end
      end
      RX_HI: begin
        if (cnt_q == '0) begin
          for (int i = 0; i < 10; i++) begin
            if (bit_q == 4'(i)) rx_d[i] = dat_f_q;
          end
        end
        if (hp_done) begin
          cnt_d = '0;
          if (bit_q == 4'd9) begin
            state_d = RX_ACK_LO;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = RX_LO;
          end
        end
      end
      RX_ACK_LO: begin
        clk_low = 1'b1;
        dat_low = 1'b1;
        if (hp_done) begin
          state_d = RX_ACK_HI;
          cnt_d   = '0;
        end
      end
      RX_ACK_HI: begin
        dat_low = 1'b1;
        if (hp_done) begin
          state_d = TX_GAP;
          cnt_d   = '0;
          // Any response replaces whatever was still queued.
          q0_d    = 8'hFA;
          q1_d    = 8'h00;
          q2_d    = 8'h00;
          qcnt_d  = 2'd1;
          if (frame_ok) begin
            cmd_byte_d  = rx_q[7:0];
            cmd_valid_d = 1'b1;
            case (rx_q[7:0])
              8'hFF: begin
                q1_d     = 8'hAA;
                q2_d     = 8'h00;
                qcnt_d   = 2'd3;
                stream_d = 1'b0;
              end
              8'hF4:        stream_d = 1'b1;
              8'hF5, 8'hF6: stream_d = 1'b0;
              default:      stream_d = stream_q;
            endcase
          end else begin
            cmd_error_d = 1'b1;
            q0_d        = 8'hFE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_mouse_device.sv
// Bench for ps2_mouse_device: plays the PS/2 host (commands, inhibit) and decodes device frames.
// Latency: timing derived from the bench's HALF_PERIOD; every wait is cycle-bounded.
// Backpressure: packets offered only when PKT_READY is seen; expectations come from a host-level model.
module tb_ps2_mouse_device;
  localparam int HP  = 20;
  localparam int RTS = 30;
  localparam int FL  = 4;

  logic       clk;
  logic       rst_n;
  logic       host_clk_low, host_dat_low, host_tx;
  logic [7:0] pkt_status, pkt_dx, pkt_dy;
  logic       pkt_valid;
  logic       pkt_ready, stream_en, cmd_valid, cmd_error, busy;
  logic [7:0] cmd_byte;
  wire        CLK_MOUSE, DATA_MOUSE;

  pullup (CLK_MOUSE);
  pullup (DATA_MOUSE);
  assign CLK_MOUSE  = host_clk_low ? 1'b0 : 1'bz;
  assign DATA_MOUSE = host_dat_low ? 1'b0 : 1'bz;

  ps2_mouse_device #(.HALF_PERIOD(HP), .RTS_SETTLE(RTS), .FILTER_LEN(FL)) dut (
    .CLK(clk), .RESET(rst_n), .CLK_MOUSE(CLK_MOUSE), .DATA_MOUSE(DATA_MOUSE),
    .PKT_STATUS(pkt_status), .PKT_DX(pkt_dx), .PKT_DY(pkt_dy), .PKT_VALID(pkt_valid),
    .PKT_READY(pkt_ready), .STREAM_EN(stream_en), .CMD_BYTE(cmd_byte),
    .CMD_VALID(cmd_valid), .CMD_ERROR(cmd_error), .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int edge_cnt = 0;
  int cv_cnt   = 0;
  int ce_cnt   = 0;
  int rd_idx   = 0;
  logic [10:0] frm_q[$];
  int          tfirst_q[$];
  int          tlast_q[$];

  // Host-level model state
  logic       exp_stream = 1'b0;
  logic [7:0] exp_cmd    = 8'h00;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (cmd_valid) cv_cnt++;
    if (cmd_error) ce_cnt++;
  end

  // Device-to-host frame decoder: data is read at each falling PS/2 clock.
  initial begin : monitor
    logic        prev;
    int          n;
    int          tf;
    logic [10:0] bits;
    prev = 1'b1;
    n    = 0;
    tf   = 0;
    bits = '0;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && CLK_MOUSE === 1'b0) begin
        edge_cnt++;
        if (!host_tx && !host_clk_low) begin
          bits = {DATA_MOUSE, bits[10:1]};
          if (n == 0) tf = cyc;
          n++;
          if (n == 11) begin
            frm_q.push_back(bits);
            tfirst_q.push_back(tf);
            tlast_q.push_back(cyc);
            n = 0;
          end
        end
      end
      if (host_clk_low) n = 0;
      prev = CLK_MOUSE;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  task automatic wait_clk_fall(output logic ok);
    logic prev;
    ok   = 1'b0;
    prev = CLK_MOUSE;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (prev === 1'b1 && CLK_MOUSE === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = CLK_MOUSE;
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (frm_q.size() > rd_idx) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    chk({tag, "_arrived"}, ok, 1'b1);
    if (ok) begin
      chk(tag, frm_q[rd_idx], {1'b1, odd_par(b), b, 1'b0});
      rd_idx++;
    end
  endtask

  // Host request-to-send, 10 host bits clocked by the device, then the device ACK.
  task automatic host_send(input logic [7:0] c, input logic flip);
    logic [9:0] b;
    logic       ok;
    b = {1'b1, odd_par(c) ^ flip, c};
    host_tx      = 1'b1;
    host_clk_low = 1'b1;
    step(3 * HP);
    host_dat_low = 1'b1;
    step(5);
    host_clk_low = 1'b0;
    for (int n = 0; n < 10; n++) begin
      wait_clk_fall(ok);
      chk("rx_clk_fall", ok, 1'b1);
      host_dat_low = ~b[n];
    end
    wait_clk_fall(ok);
    chk("ack_clk_fall", ok, 1'b1);
    step(2);
    chk("ack_data_low", DATA_MOUSE, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 4 * HP; i++) begin
      step(1);
      if (DATA_MOUSE === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ack_release", ok, 1'b1);
    host_tx = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input logic [7:0] c, input logic flip);
    int         cv0, ce0;
    logic [7:0] resp[$];
    cv0 = cv_cnt;
    ce0 = ce_cnt;
    host_send(c, flip);
    step(3);
    if (flip) begin
      resp = '{8'hFE};
    end else begin
      exp_cmd = c;
      if (c == 8'hFF) begin
        resp = '{8'hFA, 8'hAA, 8'h00};
        exp_stream = 1'b0;
      end else begin
        resp = '{8'hFA};
        if (c == 8'hF4) exp_stream = 1'b1;
        if (c == 8'hF5 || c == 8'hF6) exp_stream = 1'b0;
      end
    end
    chk({tag, "_cmd_valid"}, cv_cnt - cv0, flip ? 0 : 1);
    chk({tag, "_cmd_error"}, ce_cnt - ce0, flip ? 1 : 0);
    chk({tag, "_cmd_byte"}, cmd_byte, exp_cmd);
    chk({tag, "_stream_en"}, stream_en, exp_stream);
    foreach (resp[i]) expect_frame({tag, "_resp"}, resp[i]);
  endtask

  task automatic offer_pkt(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
    logic ok;
    ok = 1'b0;
    pkt_status = s;
    pkt_dx     = dx;
    pkt_dy     = dy;
    pkt_valid  = 1'b1;
    for (int i = 0; i < 8 * HP; i++) begin
      if (pkt_ready) begin
        ok = 1'b1;
        step(1);
        break;
      end
      step(1);
    end
    pkt_valid = 1'b0;
    chk("pkt_accepted", ok, 1'b1);
  endtask

  task automatic run_packet(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
    int base;
    offer_pkt(s, dx, dy);
    chk("pkt_ready_after_accept", pkt_ready, 1'b0);
    base = rd_idx;
    expect_frame("pkt_status", s);
    chk("pkt_ready_draining", pkt_ready, 1'b0);
    expect_frame("pkt_dx", dx);
    expect_frame("pkt_dy", dy);
    for (int k = base; k < base + 2 && k + 1 < frm_q.size(); k++)
      chk("pkt_gap", (tfirst_q[k+1] - tlast_q[k]) >= 3 * HP, 1'b1);
    step(4 * HP);
    chk("pkt_ready_drained", pkt_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] s, dy, c;
    logic       ok;
    rst_n        = 1'b0;
    host_clk_low = 1'b0;
    host_dat_low = 1'b0;
    host_tx      = 1'b0;
    pkt_status   = '0;
    pkt_dx       = '0;
    pkt_dy       = '0;
    pkt_valid    = 1'b0;
    step(5);
    chk("rst_stream_en", stream_en, 1'b0);
    chk("rst_pkt_ready", pkt_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_byte", cmd_byte, 8'h00);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_cmd_error", cmd_error, 1'b0);
    chk("rst_clk_line", CLK_MOUSE, 1'b1);
    chk("rst_data_line", DATA_MOUSE, 1'b1);
    rst_n = 1'b1;

    step(20 * HP);
    chk("idle_clk_edges", edge_cnt, 0);
    chk("idle_stream_en", stream_en, 1'b0);
    chk("idle_pkt_ready", pkt_ready, 1'b0);
    chk("idle_busy", busy, 1'b0);

    do_cmd("f4", 8'hF4, 1'b0);
    step(4 * HP);
    chk("f4_pkt_ready", pkt_ready, 1'b1);

    run_packet(8'h08, 8'h05, 8'hFB);
    for (int k = 0; k < 2; k++) run_packet(8'($urandom), 8'($urandom), 8'($urandom));

    c = 8'($urandom_range(0, 239));
    do_cmd("rand_cmd", c, 1'b0);
    step(4 * HP);

    // Host inhibit during bit 4 (data bit 3) of DX=05
    s  = 8'($urandom);
    dy = 8'($urandom);
    offer_pkt(s, 8'h05, dy);
    expect_frame("inh_status", s);
    for (int n = 0; n < 4; n++) begin
      wait_clk_fall(ok);
      chk("inh_dev_fall", ok, 1'b1);
    end
    for (int i = 0; i < 2 * HP && CLK_MOUSE !== 1'b1; i++) step(1);
    step(FL + 4);
    chk("inh_bit4_driven", DATA_MOUSE, 1'b0);
    host_clk_low = 1'b1;
    step(5 * HP);
    chk("inh_busy", busy, 1'b0);
    chk("inh_data_released", DATA_MOUSE, 1'b1);
    host_clk_low = 1'b0;
    expect_frame("inh_dx_resent", 8'h05);
    expect_frame("inh_dy", dy);
    step(4 * HP);

    // Reset command while a packet is queued: remainder of the packet dropped
    offer_pkt(8'($urandom), 8'($urandom), 8'($urandom));
    rd_idx++;  // status frame of this packet goes out before the command
    for (int i = 0; i < 2000 && frm_q.size() < rd_idx; i++) step(1);
    chk("ff_status_sent", frm_q.size(), rd_idx);
    do_cmd("ff", 8'hFF, 1'b0);
    step(4 * HP);
    chk("ff_pkt_ready", pkt_ready, 1'b0);

    do_cmd("badpar", 8'hF4, 1'b1);
    step(4 * HP);

    pkt_valid = 1'b1;
    step(10 * HP);
    chk("ignored_pkt_ready", pkt_ready, 1'b0);
    pkt_valid = 1'b0;
    step(30 * HP);
    chk("ignored_no_frames", frm_q.size(), rd_idx);
    chk("ignored_busy", busy, 1'b0);

    do_cmd("f5", 8'hF5, 1'b0);
    do_cmd("f4b", 8'hF4, 1'b0);
    do_cmd("f6", 8'hF6, 1'b0);
    step(40 * HP);
    chk("final_no_extra_frames", frm_q.size(), rd_idx);
    chk("final_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ps2_mouse_device.md
Name: ps2_mouse_device

Overview:
Device-side PS/2 mouse model. It is the far end of the host mouse transceiver, used for on-board loopback and for system benches. It generates the PS/2 clock, answers host commands (reset, enable/disable streaming), and transmits 3-byte movement packets injected on a valid/ready port. All PS/2 signalling is open-drain: the block only ever pulls CLK_MOUSE and DATA_MOUSE low or releases them, and pull-ups are external.

Parameters:
HALF_PERIOD, 3500, CLK cycles per PS/2 clock half-phase (100 MHz gives about 14.3 kHz).
RTS_SETTLE, 1000, CLK cycles that CLK_MOUSE must be high and DATA_MOUSE low before a host request-to-send is accepted.
FILTER_LEN, 8, number of consecutive equal samples needed to accept a level change on each PS/2 line.

Ports:
CLK  in  1  system clock.
RESET  in  1  asynchronous, active-low reset.
CLK_MOUSE  inout  1  PS/2 clock; driven 0 or z.
DATA_MOUSE  inout  1  PS/2 data; driven 0 or z.
PKT_STATUS  in  8  packet byte 0 (status/button byte).
PKT_DX  in  8  packet byte 1.
PKT_DY  in  8  packet byte 2.
PKT_VALID  in  1  packet offered.
PKT_READY  out  1  packet accepted on the cycle PKT_VALID and PKT_READY are both high.
STREAM_EN  out  1  streaming enabled by the host.
CMD_BYTE  out  8  last command byte received from the host.
CMD_VALID  out  1  one-cycle pulse; a command byte was received with good parity.
CMD_ERROR  out  1  one-cycle pulse; a received frame had bad parity or bad stop bit.
BUSY  out  1  high whenever the state machine is not in IDLE.

Behaviour:
- Reset (RESET=0, asynchronous): both lines released (z), STREAM_EN=0, CMD_BYTE=00, CMD_VALID=0, CMD_ERROR=0, PKT_READY=0, BUSY=0, queue empty, state IDLE.
- Both lines pass through FILTER_LEN-deep shift-register filters. All decisions use the filtered levels.
- Queue: 3-entry byte FIFO shared by command responses and packets. A new response load overwrites (flushes) the queue contents.
- PKT_READY = STREAM_EN & queue empty & state IDLE. On acceptance, the queue is loaded with STATUS, DX, DY in that order.
- Frame format: start 0, D0..D7 (LSB first), odd parity, stop 1. Odd parity means the parity bit is ~^data.
- States: IDLE, TX_HI, TX_LO, TX_GAP, RX_WAIT, RX_LO, RX_HI, RX_ACK_LO, RX_ACK_HI.
- IDLE:
  - If filtered CLK=1 and DATA=0 → RX_WAIT.
  - Otherwise, if the queue is non-empty and CLK=1 → TX_HI with bit index 0.
  - The RTS check has priority over transmitting.
- TX_HI: drive DATA with the current bit (0 → pull low, 1 → release), release CLK, hold HALF_PERIOD cycles → TX_LO.
- TX_LO: pull CLK low for HALF_PERIOD cycles. After bit 10, pop the queue → TX_GAP. Otherwise increment the bit index → TX_HI.
- TX_GAP: release both lines for 2*HALF_PERIOD cycles → IDLE.
- Host inhibit during transmission:
  - In TX_HI with bit index ≤ 9, filtered CLK=0 (the host is holding it low) aborts the frame. The byte is not popped; lines are released → IDLE. The whole byte is resent later.
  - Inhibit during bit 10 is ignored; the byte counts as sent.
- RX_WAIT:
  - Count cycles while CLK=1 and DATA=0; reaching RTS_SETTLE → RX_LO with bit index 0.
  - DATA returning high first → IDLE.
- RX_LO: pull CLK low for HALF_PERIOD cycles → RX_HI.
- RX_HI: release CLK. Sample DATA at the first cycle of the phase into the shift register at the bit index (0..7 data, 8 parity, 9 stop). Hold HALF_PERIOD cycles. After index 9 → RX_ACK_LO; otherwise → RX_LO.
- RX_ACK_LO: pull DATA low and pull CLK low for HALF_PERIOD cycles → RX_ACK_HI.
- RX_ACK_HI: release CLK, hold HALF_PERIOD cycles, release DATA. Then evaluate the frame → TX_GAP.
- Frame evaluation:
  - Parity and stop bit good: CMD_BYTE updated, CMD_VALID pulses, queue loaded with the response.
  - Otherwise: CMD_ERROR pulses, CMD_BYTE unchanged, queue loaded with FE.
- Command responses (the queue is flushed first, so any pending packet is dropped):
  - FF → FA, AA, 00; STREAM_EN=0.
  - F4 → FA; STREAM_EN=1.
  - F5 or F6 → FA; STREAM_EN=0.
  - Any other byte → FA; STREAM_EN unchanged.
- STREAM_EN changes on the evaluation cycle.
- PKT_VALID is ignored while PKT_READY=0. There is no buffering of offered packets.

Test Plan:
- Reset released; host idle for 10 PS/2 periods → no CLK_MOUSE edges; STREAM_EN=0; PKT_READY=0.
- Host sends F4 → device ACK: DATA low during the 11th clock; CMD_VALID pulse; CMD_BYTE=F4; one frame FA returned with parity=1; STREAM_EN=1; PKT_READY=1.
- With STREAM_EN=1, offer STATUS=08, DX=05, DY=FB → frames 08 (parity 0), 05 (parity 1), FB (parity 0), separated by ≥2*HALF_PERIOD gaps; PKT_READY low until the queue drains.
- Host sends FF mid-stream, with a packet queued → the packet is dropped; frames FA, AA, 00 are sent; STREAM_EN=0.
- Host sends F4 with the parity bit flipped → CMD_ERROR pulse; CMD_BYTE unchanged; FE sent; STREAM_EN unchanged.
- Host holds CLK_MOUSE low for 200 µs during bit 4 of byte DX=05 → frame aborted, lines released; after release, all 11 bits of 05 are resent, then DY follows.
